// File: rtl/display_pkg.sv
// Shared constants, FSM state type and seven-segment glyph patterns
// for the four-digit multiplexed display scanner.
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DIGIT_W    = $clog2(NUM_DIGITS);
    localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Glyphs as {a,b,c,d,e,f,g}, active-high; F is deliberately dark.
    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A = 7'b0001101;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_C = 7'b0100011;
    localparam logic [SEG_W-1:0] SEG_D = 7'b1001011;
    localparam logic [SEG_W-1:0] SEG_E = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_F = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to seven-segment glyph decoder.
//   i_nibble : hex value 0-F
//   o_seg    : segments {a,b,c,d,e,f,g}, active-high
module seg7_decode
    import display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_nibble,
    output logic [SEG_W-1:0]    o_seg
);

    always_comb begin
        o_seg = SEG_F;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            default: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with double-buffered load.
//   clk, rst        : clock and synchronous active-high reset
//   enable          : run the scan (IDLE <-> SCAN)
//   blank_lz        : suppress leading zeros on digits 3..1
//   load_valid/data : new 4-nibble value into the pending buffer
//   load_ready      : pending buffer empty
//   seg, an         : registered segment and anode drives, active-high
//   frame_done      : one-cycle pulse on the last tick of digit 3
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 1000,
    parameter int unsigned GHOST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              blank_lz,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic [SEG_W-1:0]  seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic              frame_done
);

    localparam int unsigned TICK_W = $clog2(CLK_DIV);
    localparam logic [TICK_W-1:0]  TICK_MAX   = TICK_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0]  TICK_GHOST = TICK_W'(GHOST_CYC);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(NUM_DIGITS - 1);

    state_t              r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [DIGIT_W-1:0]  r_digit;
    logic [DATA_W-1:0]   r_active;
    logic [DATA_W-1:0]   r_pending;
    logic                r_pend_full;

    state_t              w_state_nx;
    logic [TICK_W-1:0]   w_tick_nx;
    logic [DIGIT_W-1:0]  w_digit_nx;
    logic [DATA_W-1:0]   w_active_nx;
    logic [DATA_W-1:0]   w_upper;
    logic [NIBBLE_W-1:0] w_nibble;
    logic [SEG_W-1:0]    w_seg_dec;
    logic [SEG_W-1:0]    w_seg_nx;
    logic [NUM_DIGITS-1:0] w_an_nx;
    logic                w_fd_nx;
    logic                w_boundary;
    logic                w_accept;
    logic                w_xfer;
    logic                w_lit;

    assign load_ready = ~r_pend_full;

    // Next scan position and buffer movement.
    always_comb begin
        w_state_nx = r_state;
        w_tick_nx  = r_tick;
        w_digit_nx = r_digit;
        w_boundary = (r_state == SCAN) && (r_digit == DIGIT_MAX) && (r_tick == TICK_MAX);
        w_accept   = load_valid && !r_pend_full;
        // In IDLE pending drains immediately; in SCAN only at the frame boundary.
        w_xfer     = r_pend_full && ((r_state == IDLE) || w_boundary);
        w_active_nx = w_xfer ? r_pending : r_active;
        case (r_state)
            IDLE: begin
                w_tick_nx  = '0;
                w_digit_nx = '0;
                if (enable) begin
                    w_state_nx = SCAN;
                end
            end
            SCAN: begin
                if (!enable) begin
                    w_state_nx = IDLE;
                    w_tick_nx  = '0;
                    w_digit_nx = '0;
                end else if (r_tick == TICK_MAX) begin
                    w_tick_nx  = '0;
                    w_digit_nx = r_digit + DIGIT_W'(1);
                end else begin
                    w_tick_nx  = r_tick + TICK_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_tick_nx  = '0;
                w_digit_nx = '0;
            end
        endcase
    end

    // Outputs are computed from the next position so the registered drives
    // line up with the tick/digit they describe.
    always_comb begin
        w_upper  = w_active_nx >> {w_digit_nx, 2'b00};
        w_nibble = w_upper[NIBBLE_W-1:0];
        w_lit    = (w_state_nx == SCAN) && (w_tick_nx >= TICK_GHOST);
        w_seg_nx = '0;
        w_an_nx  = '0;
        if (w_lit) begin
            w_an_nx = NUM_DIGITS'(1) << w_digit_nx;
            // Digit k is a leading zero when nibbles k..3 are all zero.
            if (!(blank_lz && (w_digit_nx != '0) && (w_upper == '0))) begin
                w_seg_nx = w_seg_dec;
            end
        end
        w_fd_nx = (w_state_nx == SCAN) && (w_digit_nx == DIGIT_MAX) && (w_tick_nx == TICK_MAX);
    end

    seg7_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

    // State, buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_digit     <= '0;
            r_active    <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            seg         <= '0;
            an          <= '0;
            frame_done  <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_tick     <= w_tick_nx;
            r_digit    <= w_digit_nx;
            r_active   <= w_active_nx;
            seg        <= w_seg_nx;
            an         <= w_an_nx;
            frame_done <= w_fd_nx;
            if (w_accept) begin
                r_pending   <= load_data;
                r_pend_full <= 1'b1;
            end else if (w_xfer) begin
                r_pend_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (CLK_DIV=8, GHOST_CYC=2).
module tb_display_scan_ctrl;

    localparam int CD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = 4 * CD;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        blank_lz;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
        logic       lr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tab [16];

    logic        m_started = 1'b0;
    logic        m_scan    = 1'b0;
    int          m_pos     = 0;
    logic [15:0] m_active  = '0;
    logic [15:0] m_pending = '0;
    logic        m_pfull   = 1'b0;

    display_scan_ctrl #(.CLK_DIV(CD), .GHOST_CYC(GC)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b0001101, 7'b0011001,
                    7'b0100011, 7'b1001011, 7'b0001111, 7'b0000000};
    end

    // Expected outputs for a frame position (cycles since SCAN entry).
    function automatic exp_t predict(input logic sc, input int p, input logic [15:0] act,
                                     input logic blz, input logic pf);
        exp_t        e;
        int          dig;
        int          tk;
        logic [15:0] upper;
        e    = '0;
        e.lr = ~pf;
        if (sc) begin
            dig  = p / CD;
            tk   = p % CD;
            e.fd = (p == FRAME - 1);
            if (tk >= GC) begin
                e.an  = 4'(1 << dig);
                upper = act >> (4 * dig);
                if (!(blz && dig > 0 && upper == 16'h0000))
                    e.seg = seg_tab[upper[3:0]];
            end
        end
        return e;
    endfunction

    // Reference model: advances once per clock and queues the expected drives.
    always @(posedge clk) begin : model
        logic        sc_n;
        logic        pf_n;
        int          p_n;
        logic [15:0] act_n;
        logic [15:0] pend_n;
        logic        bnd;
        logic        acc;
        logic        xf;
        if (rst) begin
            m_started <= 1'b1;
            m_scan    <= 1'b0;
            m_pos     <= 0;
            m_active  <= '0;
            m_pending <= '0;
            m_pfull   <= 1'b0;
            q.push_back(predict(1'b0, 0, 16'h0000, 1'b0, 1'b0));
        end else if (m_started) begin
            bnd    = m_scan && (m_pos == FRAME - 1);
            acc    = load_valid && !m_pfull;
            xf     = m_pfull && (!m_scan || bnd);
            act_n  = xf ? m_pending : m_active;
            pend_n = acc ? load_data : m_pending;
            pf_n   = acc ? 1'b1 : (xf ? 1'b0 : m_pfull);
            if (!m_scan) begin
                sc_n = enable;
                p_n  = 0;
            end else if (!enable) begin
                sc_n = 1'b0;
                p_n  = 0;
            end else begin
                sc_n = 1'b1;
                p_n  = (m_pos + 1) % FRAME;
            end
            m_scan    <= sc_n;
            m_pos     <= p_n;
            m_active  <= act_n;
            m_pending <= pend_n;
            m_pfull   <= pf_n;
            q.push_back(predict(sc_n, p_n, act_n, blank_lz, pf_n));
        end
    end

    // Monitor: compare registered outputs mid-cycle against the queue head.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, frame_done, load_ready} !== e) begin
                errors++;
                $display("FAIL outputs t=%0t an=%b exp %b seg=%b exp %b fd=%b exp %b lr=%b exp %b",
                         $time, an, e.an, seg, e.seg, frame_done, e.fd, load_ready, e.lr);
            end
            checks++;
            if (!$onehot0(an)) begin
                errors++;
                $display("FAIL an_onehot t=%0t an=%b exp one-hot or zero", $time, an);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d);
        int   n;
        logic ok;
        n          = 0;
        load_valid = 1'b1;
        load_data  = d;
        forever begin
            ok = load_ready;
            step();
            if (ok) break;
            n++;
            if (n > 4 * FRAME) begin
                checks++;
                errors++;
                $display("FAIL load_wait data=%h load_ready=%b exp 1 within %0d cycles",
                         d, load_ready, 4 * FRAME);
                break;
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        int n;
        n = 0;
        while (!(m_scan && m_pos == target)) begin
            step();
            n++;
            if (n > 4 * FRAME) begin
                checks++;
                errors++;
                $display("FAIL pos_wait pos=%0d exp %0d", m_pos, target);
                break;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        blank_lz   = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Basic scan of 1234.
        do_load(16'h1234);
        enable = 1'b1;
        repeat (70) step();

        // Leading-zero blanking, all-zero value, and the dark F glyph.
        blank_lz = 1'b1;
        do_load(16'h0070);
        repeat (70) step();
        do_load(16'h0000);
        repeat (70) step();
        blank_lz = 1'b0;
        do_load(16'hF0F0);
        repeat (40) step();

        // Back-to-back loads mid-frame: second stalls until the boundary.
        wait_pos(10);
        do_load(16'hABCD);
        do_load(16'h5555);
        repeat (100) step();

        // Drop enable during digit 2 tick 5, then re-enable.
        wait_pos(2 * CD + 5);
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        repeat (45) step();

        // Reset in SCAN with pending full.
        wait_pos(5);
        do_load(16'h9876);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (45) step();

        // Randomised traffic.
        for (int i = 0; i < 900; i++) begin
            rst        = ($urandom_range(0, 249) == 0);
            enable     = ($urandom_range(0, 24) != 0);
            if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            load_valid = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++)
                load_data[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step();
        end

        rst        = 1'b0;
        load_valid = 1'b0;
        enable     = 1'b1;
        repeat (5) step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1000: clock cycles per digit slot, minimum 4.
REQ-002 SHALL have parameter GHOST_CYC, default 2: anode-off cycles at the start of each slot, range 1 to CLK_DIV-2.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port enable, input, 1: scan enable.
REQ-006 SHALL have port blank_lz, input, 1: leading-zero blanking enable.
REQ-007 SHALL have port load_valid, input, 1: load request.
REQ-008 SHALL have port load_data, input, 16: four hex nibbles; [3:0] is digit 0 (rightmost).
REQ-009 SHALL have port load_ready, output, 1: pending buffer empty.
REQ-010 SHALL have port seg, output, 7: segments {a,b,c,d,e,f,g}, MSB = a, active-high.
REQ-011 SHALL have port an, output, 4: digit enables, active-high, one-hot or zero; an[k] drives digit k.
REQ-012 SHALL have port frame_done, output, 1: single-cycle pulse at the end of each digit-3 slot.

Function
REQ-013 SHALL implement states IDLE and SCAN: IDLE->SCAN when enable=1; SCAN->IDLE on the first cycle enable=0.
REQ-014 SHALL, in IDLE, drive an=0 and seg=0, hold the tick counter and digit index at 0, and move pending to active one cycle after a load is accepted.
REQ-015 SHALL count ticks 0..CLK_DIV-1 in SCAN; at tick CLK_DIV-1, tick returns to 0 and the digit index advances 0->1->2->3->0.
REQ-016 SHALL register seg and an; for slot ticks 0..GHOST_CYC-1 drive an=0 and seg=0; for ticks GHOST_CYC..CLK_DIV-1 drive an=one-hot(digit) and seg=decode(active nibble).
REQ-017 SHALL decode nibble values 0-F (abcdefg) as: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 0001101, 0011001, 0100011, 1001011, 0001111, 0000000.
REQ-018 SHALL, when blank_lz=1, force seg=0 for digit k (k=1..3) if active nibbles k..3 are all 0; digit 0 SHALL never be blanked.
REQ-019 SHALL accept a load when load_valid and load_ready are both 1 in the same cycle, capturing load_data into the pending buffer and setting pending-full.
REQ-020 SHALL drive load_ready = NOT pending-full.
REQ-021 SHALL, in SCAN, transfer pending to active only on the frame-boundary cycle (digit 3, tick CLK_DIV-1); load_ready SHALL rise the following cycle.
REQ-022 SHALL NOT accept a new load on the frame-boundary cycle while pending is full (load_ready is 0 then).
REQ-023 SHALL, for a load accepted on a boundary cycle with pending empty, place the data in pending and transfer it at the next boundary.
REQ-024 SHALL assert frame_done for exactly the frame-boundary cycle while in SCAN, and never in IDLE.
REQ-025 SHALL, on enable deassertion mid-frame, reset tick and digit to 0, drive an=0 and seg=0 from the next cycle, and retain the active and pending contents.
REQ-026 SHALL start every SCAN entry at digit 0, tick 0.

Reset
REQ-027 SHALL, when rst=1 at a clock edge, set state=IDLE, tick=0, digit=0, active=16'h0000, pending empty, seg=0, an=0, frame_done=0 and load_ready=1.
REQ-028 SHALL give rst priority over enable and over any load.

Structure
REQ-029 SHALL place in package display_pkg: NUM_DIGITS=4, the state enum, and the 16 segment pattern constants.
REQ-030 SHALL instantiate one sub-module, seg7_decode (combinational, 4-bit in, 7-bit out, table per REQ-017).
REQ-031 SHALL keep the tick counter width at $clog2(CLK_DIV).

Verification (CLK_DIV=8, GHOST_CYC=2)
REQ-032 Reset, enable=1, load 16'h1234 -> digit 0 slot: an=0001, seg=0110011 at ticks 2-7; digit 3 slot: an=1000, seg=0110000; frame_done every 32 cycles.
REQ-033 blank_lz=1, active 16'h0070 -> digits 3 and 2 seg=0, digit 1 seg=1110000, digit 0 seg=1111110; active 16'h0000 -> only digit 0 shows 1111110.
REQ-034 Mid-frame load 16'hABCD then 16'h5555 -> first accepted, load_ready=0 until the boundary, second stalls; the following frame shows ABCD; 5555 is accepted after the boundary and shown one frame later.
REQ-035 enable dropped at digit 2 tick 5 -> an=0 and seg=0 the next cycle; re-enable -> digit 0 at tick 0, active data unchanged.
REQ-036 rst pulsed during SCAN with pending full -> all outputs reach reset values, load_ready=1, and the display shows 0 after re-enable.
REQ-037 Nibble F -> seg=0 on that digit; an stays one-hot and is never multi-hot across the whole run (assertion).
